regex_job_dispatcher: RTL

- Sits between a core-side job source and ACCEL_COUNT regex accelerator instances (cmd_addr/cmd_len/cmd_valid/cmd_ready, status_done/status_match per instance).
- Accepts scan jobs and dispatches each to an idle accelerator, round-robin.
- Tracks each accelerator through issue, run and completion.
- Returns {tag, match, accel index} results through a round-robin-arbitrated valid/ready output.

---
 rtl/regex_disp_pkg.sv | 25 ++
 rtl/regex_job_dispatcher_if.sv | 58 +++++
 rtl/regex_job_dispatcher_rr_pick.sv | 43 ++++
 rtl/regex_job_dispatcher.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/regex_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regex_disp_pkg
//  Description : Shared types and default widths for the regex job dispatcher.
//                Holds the per-slot lifecycle state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package regex_disp_pkg;

    localparam int DEF_ACCEL_COUNT = 8;
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_LEN_WIDTH   = 16;
    localparam int DEF_TAG_WIDTH   = 8;

    // Accelerator slot lifecycle.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,  // free, eligible for a new job
        S_ISSUE    = 3'd1,  // command offered to the accelerator
        S_WAIT_CLR = 3'd2,  // waiting for done to drop (discards stale done)
        S_RUN      = 3'd3,  // scanning, waiting for done to rise
        S_REPORT   = 3'd4   // result pending for the output stage
    } slot_state_e;

endpackage
`default_nettype wire

// File: rtl/regex_job_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : regex_job_dispatcher_if
//  Description : Bundles the job input, per-accelerator command/status and
//                result output of the regex job dispatcher.
//  Ports       : job_*    - job offer (valid/ready)
//                cmd_*    - per-slot command, flat packed (valid/ready)
//                status_* - per-slot done level and match flag
//                res_*    - result output (valid/ready)
//                busy_count - number of non-idle slots
//  Modports    : slave  - the dispatcher
//                master - the job source / accelerators / result sink
//  Revision    : 1.0 - initial release
// ============================================================================
interface regex_job_dispatcher_if #(
    parameter int ACCEL_COUNT          = 8,
    parameter int SLOW_DMEM_ADDR_WIDTH = 8,
    parameter int LEN_WIDTH            = 16,
    parameter int TAG_WIDTH            = 8,
    parameter int IDX_WIDTH            = $clog2(ACCEL_COUNT)
);
    logic [SLOW_DMEM_ADDR_WIDTH-1:0]             job_addr;
    logic [LEN_WIDTH-1:0]                        job_len;
    logic [TAG_WIDTH-1:0]                        job_tag;
    logic                                        job_valid;
    logic                                        job_ready;

    logic [ACCEL_COUNT*SLOW_DMEM_ADDR_WIDTH-1:0] cmd_addr;
    logic [ACCEL_COUNT*LEN_WIDTH-1:0]            cmd_len;
    logic [ACCEL_COUNT-1:0]                      cmd_valid;
    logic [ACCEL_COUNT-1:0]                      cmd_ready;
    logic [ACCEL_COUNT-1:0]                      status_done;
    logic [ACCEL_COUNT-1:0]                      status_match;

    logic [TAG_WIDTH-1:0]                        res_tag;
    logic                                        res_match;
    logic [IDX_WIDTH-1:0]                        res_idx;
    logic                                        res_valid;
    logic                                        res_ready;

    logic [IDX_WIDTH:0]                          busy_count;

    modport slave (
        input  job_addr, job_len, job_tag, job_valid,
        input  cmd_ready, status_done, status_match, res_ready,
        output job_ready, cmd_addr, cmd_len, cmd_valid,
        output res_tag, res_match, res_idx, res_valid, busy_count
    );

    modport master (
        output job_addr, job_len, job_tag, job_valid,
        output cmd_ready, status_done, status_match, res_ready,
        input  job_ready, cmd_addr, cmd_len, cmd_valid,
        input  res_tag, res_match, res_idx, res_valid, busy_count
    );

endinterface
`default_nettype wire

// File: rtl/regex_job_dispatcher_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin finder. Returns the first set bit
//                of req_i at or after ptr_i, wrapping around.
//  Ports       : req_i    - request vector
//                ptr_i    - starting index
//                onehot_o - one-hot grant
//                idx_o    - grant index
//                any_o    - at least one request set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] w_k;

    // N is a power of two, so the index adder wraps naturally.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        w_k      = '0;
        for (int i = 0; i < N; i++) begin
            w_k = ptr_i + IDX_W'(i);
            if (!any_o && req_i[w_k]) begin
                onehot_o[w_k] = 1'b1;
                idx_o         = w_k;
                any_o         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regex_job_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : regex_job_dispatcher
//  Description : Dispatches scan jobs round-robin to idle regex accelerators,
//                tracks each slot through issue/run/completion and returns
//                {tag, match, slot} results through a registered output stage
//                with round-robin arbitration among completed slots.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                bus  - regex_job_dispatcher_if.slave (job, cmd, status,
//                       result and busy_count signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module regex_job_dispatcher
    import regex_disp_pkg::*;
#(
    parameter int ACCEL_COUNT          = DEF_ACCEL_COUNT,
    parameter int SLOW_DMEM_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH            = DEF_LEN_WIDTH,
    parameter int TAG_WIDTH            = DEF_TAG_WIDTH,
    parameter int IDX_WIDTH            = $clog2(ACCEL_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    regex_job_dispatcher_if.slave  bus
);

    localparam int N  = ACCEL_COUNT;
    localparam int AW = SLOW_DMEM_ADDR_WIDTH;
    localparam int LW = LEN_WIDTH;
    localparam int TW = TAG_WIDTH;

    localparam logic [IDX_WIDTH-1:0] IDX_ONE = 1;
    localparam logic [IDX_WIDTH:0]   CNT_ONE = 1;

    // Per-slot state and latched job
    slot_state_e             state_q [N];
    slot_state_e             state_d [N];
    logic [AW-1:0]           addr_q  [N];
    logic [LW-1:0]           len_q   [N];
    logic [TW-1:0]           tag_q   [N];
    logic                    match_q [N];

    logic [IDX_WIDTH-1:0]    issue_ptr_q;
    logic [IDX_WIDTH-1:0]    res_ptr_q;

    // Output stage
    logic                    res_valid_q;
    logic [TW-1:0]           res_tag_q;
    logic                    res_match_q;
    logic [IDX_WIDTH-1:0]    res_idx_q;

    logic [IDX_WIDTH:0]      busy_count_q;
    logic [IDX_WIDTH:0]      busy_count_d;

    logic [N-1:0]            w_idle;
    logic [N-1:0]            w_report;
    logic [N-1:0]            w_issue_onehot;
    logic [IDX_WIDTH-1:0]    w_issue_idx;
    logic                    w_issue_any;
    logic [N-1:0]            w_res_onehot;
    logic [IDX_WIDTH-1:0]    w_res_idx;
    logic                    w_res_any;
    logic                    w_job_ready;
    logic                    w_job_take;
    logic                    w_res_load;
    logic [N*AW-1:0]         w_cmd_addr;
    logic [N*LW-1:0]         w_cmd_len;
    logic [N-1:0]            w_cmd_valid;

    // Eligibility is taken from registered state only, so a slot freed by
    // the output stage this cycle can take a new job no earlier than next.
    always_comb begin
        w_idle   = '0;
        w_report = '0;
        for (int n = 0; n < N; n++) begin
            w_idle[n]   = (state_q[n] == S_IDLE);
            w_report[n] = (state_q[n] == S_REPORT);
        end
    end

    rr_pick #(.N(N), .IDX_W(IDX_WIDTH)) u_issue_pick (
        .req_i    (w_idle),
        .ptr_i    (issue_ptr_q),
        .onehot_o (w_issue_onehot),
        .idx_o    (w_issue_idx),
        .any_o    (w_issue_any)
    );

    rr_pick #(.N(N), .IDX_W(IDX_WIDTH)) u_res_pick (
        .req_i    (w_report),
        .ptr_i    (res_ptr_q),
        .onehot_o (w_res_onehot),
        .idx_o    (w_res_idx),
        .any_o    (w_res_any)
    );

    assign w_job_ready = !rst && w_issue_any;
    assign w_job_take  = bus.job_valid && w_job_ready;
    // Load when the stage is empty or drains this cycle: one result/cycle.
    assign w_res_load  = w_res_any && (!res_valid_q || bus.res_ready);

    // Slot next-state and busy population count
    always_comb begin
        busy_count_d = '0;
        for (int n = 0; n < N; n++) begin
            state_d[n] = state_q[n];
            case (state_q[n])
                S_IDLE:     if (w_job_take && w_issue_onehot[n]) state_d[n] = S_ISSUE;
                S_ISSUE:    if (bus.cmd_ready[n])                state_d[n] = S_WAIT_CLR;
                // A done still high from the previous job must fall first.
                S_WAIT_CLR: if (!bus.status_done[n])             state_d[n] = S_RUN;
                S_RUN:      if (bus.status_done[n])              state_d[n] = S_REPORT;
                S_REPORT:   if (w_res_load && w_res_onehot[n])   state_d[n] = S_IDLE;
                default:                                         state_d[n] = S_IDLE;
            endcase
            if (state_d[n] != S_IDLE) begin
                busy_count_d = busy_count_d + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < N; n++) begin
                state_q[n] <= S_IDLE;
                addr_q[n]  <= '0;
                len_q[n]   <= '0;
                tag_q[n]   <= '0;
                match_q[n] <= 1'b0;
            end
            issue_ptr_q  <= '0;
            res_ptr_q    <= '0;
            res_valid_q  <= 1'b0;
            res_tag_q    <= '0;
            res_match_q  <= 1'b0;
            res_idx_q    <= '0;
            busy_count_q <= '0;
        end else begin
            for (int n = 0; n < N; n++) begin
                state_q[n] <= state_d[n];
                if (w_job_take && w_issue_onehot[n]) begin
                    addr_q[n] <= bus.job_addr;
                    len_q[n]  <= bus.job_len;
                    tag_q[n]  <= bus.job_tag;
                end
                if (state_q[n] == S_RUN && bus.status_done[n]) begin
                    match_q[n] <= bus.status_match[n];
                end
            end
            if (w_job_take) begin
                issue_ptr_q <= w_issue_idx + IDX_ONE;
            end
            if (w_res_load) begin
                res_valid_q <= 1'b1;
                res_tag_q   <= tag_q[w_res_idx];
                res_match_q <= match_q[w_res_idx];
                res_idx_q   <= w_res_idx;
                res_ptr_q   <= w_res_idx + IDX_ONE;
            end else if (bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
            busy_count_q <= busy_count_d;
        end
    end

    always_comb begin
        w_cmd_addr  = '0;
        w_cmd_len   = '0;
        w_cmd_valid = '0;
        for (int n = 0; n < N; n++) begin
            w_cmd_addr[n*AW +: AW] = addr_q[n];
            w_cmd_len[n*LW +: LW]  = len_q[n];
            w_cmd_valid[n]         = (state_q[n] == S_ISSUE);
        end
    end

    assign bus.job_ready  = w_job_ready;
    assign bus.cmd_addr   = w_cmd_addr;
    assign bus.cmd_len    = w_cmd_len;
    assign bus.cmd_valid  = w_cmd_valid;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_tag    = res_tag_q;
    assign bus.res_match  = res_match_q;
    assign bus.res_idx    = res_idx_q;
    assign bus.busy_count = busy_count_q;

endmodule
`default_nettype wire
